// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED bank scheduler.
//   N_REQ / LED_W : requester count and LED bank width
//   state_t       : scheduler FSM encoding
//   IDLE_RST      : running-light start pattern
//   rr_pick()     : round-robin search starting one past the last owner
package led_sched_pkg;

   localparam int N_REQ = 4;
   localparam int LED_W = 10;
   localparam int PTR_W = 2;

   localparam logic [LED_W-1:0] IDLE_RST = 10'h001;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   // Walks ptr+N_REQ down to ptr+1 so the lowest offset set bit wins last;
   // offset N_REQ wraps to ptr itself, letting a sole requester win again.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                                input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] idx;
      rr_pick = ptr;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = ptr + PTR_W'(k);
         if (req_v[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Display tick generator.
//   clk   : system clock
//   reset : synchronous active-high reset
//   tick  : one-cycle pulse every DECIMATION cycles (combinational from counter)
module led_tick_gen #(
   parameter logic [19:0] DECIMATION = 20'd1000000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   logic [19:0] cnt_q, cnt_d;

   assign tick  = (cnt_q == DECIMATION - 20'd1);
   assign cnt_d = tick ? 20'd0 : cnt_q + 20'd1;

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 20'd0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_sched.sv
// Time-shares the LED bank between four requesters and an idle running light.
//   clk, reset : system clock, synchronous active-high reset
//   req        : level-sensitive display requests
//   req_pat    : requester patterns, requester i at [10*i+9:10*i]
//   runled     : registered LED drive
//   grant      : one-hot current owner, 0 when idle
//   busy       : a requester owns the bank
//   tick       : display tick pulse
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | running light shown, rotates on each tick
// SHOW  | owner ptr_q shows its live pattern; hold_q counts ticks left
module led_sched
   import led_sched_pkg::*;
#(
   parameter logic [19:0] DECIMATION = 20'd1000000,
   parameter logic [7:0]  HOLD_TICKS = 8'd8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*LED_W-1:0] req_pat,
   output logic [LED_W-1:0]       runled,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic                   tick
);

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [7:0]         hold_q, hold_d;
   logic [LED_W-1:0]   idle_q, idle_d;
   logic [LED_W-1:0]   runled_q, runled_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [LED_W-1:0]   pat [N_REQ];
   logic [PTR_W-1:0]   win;
   logic               any_req;
   logic               end_grant;

   led_tick_gen #(.DECIMATION(DECIMATION)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pat
      assign pat[gi] = req_pat[gi*LED_W +: LED_W];
   end

   assign win     = rr_pick(req, ptr_q);
   assign any_req = |req;
   // ptr_q doubles as the owner index while in SHOW.
   assign end_grant = !req[ptr_q] || (tick && (hold_q <= 8'd1));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      idle_d  = idle_q;
      case (state_q)
         IDLE: begin
            if (tick) idle_d = {idle_q[LED_W-2:0], idle_q[LED_W-1]};
            if (any_req) begin
               state_d = SHOW;
               ptr_d   = win;
               hold_d  = HOLD_TICKS;
            end
         end
         SHOW: begin
            if (end_grant) begin
               if (any_req) begin
                  ptr_d  = win;
                  hold_d = HOLD_TICKS;
               end else begin
                  state_d = IDLE;
                  hold_d  = 8'd0;
               end
            end else if (tick) begin
               hold_d = hold_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs follow the next state so they are valid one cycle after the decision.
   always_comb begin
      runled_d = idle_d;
      grant_d  = '0;
      if (state_d == SHOW) begin
         runled_d = pat[ptr_d];
         grant_d  = N_REQ'(1) << ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= PTR_W'(N_REQ - 1);
         hold_q   <= 8'd0;
         idle_q   <= IDLE_RST;
         runled_q <= IDLE_RST;
         grant_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
         idle_q   <= idle_d;
         runled_q <= runled_d;
         grant_q  <= grant_d;
      end
   end

   assign runled = runled_q;
   assign grant  = grant_q;
   assign busy   = (state_q == SHOW);

endmodule
